// File: rtl/acc_breg_seq.sv
// SAP-1 operand stage: ACC/BREG registers feeding the adder-subtractor, one LDA/ADD/SUB/NOP per handshake.
// Latency accept->done_o: LDA 2, ADD/SUB 3, NOP 1 cycles; op_ready_o returns with done_o.
// Backpressure: op_ready_o high only in IDLE; op_valid_i outside IDLE is dropped, not queued. Option: ACC_FLAGS_EN.
module acc_breg_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] w_in_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] breg_o,
    output logic             s_u_o,
    input  logic [WIDTH-1:0] alu_s_i,
    output logic             busy_o,
`ifdef ACC_FLAGS_EN
    output logic             c_flag_o,
    output logic             z_flag_o,
`endif
    output logic             done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [1:0]       opc_q, opc_d;
    logic             s_u_q, s_u_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            breg_q  <= '0;
            opnd_q  <= '0;
            opc_q   <= OP_NOP;
            s_u_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            breg_q  <= breg_d;
            opnd_q  <= opnd_d;
            opc_q   <= opc_d;
            s_u_q   <= s_u_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        breg_d  = breg_q;
        opnd_d  = opnd_q;
        opc_d   = opc_q;
        s_u_d   = s_u_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    opc_d  = op_i;
                    opnd_d = w_in_i;
                    case (op_i)
                        OP_LDA:  state_d = LOAD_A;
                        OP_NOP:  state_d = FINISH;
                        default: state_d = LOAD_B;
                    endcase
                end
            end
            LOAD_A: begin
                acc_d   = opnd_q;
                state_d = FINISH;
            end
            LOAD_B: begin
                breg_d  = opnd_q;
                s_u_d   = (opc_q == OP_SUB);
                state_d = EXEC;
            end
            // ALU result already reflects the BREG/S_U written on the previous edge
            EXEC: begin
                acc_d   = alu_s_i;
                state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ACC_FLAGS_EN
    logic             c_flag_q, z_flag_q;
    logic [WIDTH:0]   carry_sum;
    logic [WIDTH-1:0] b_term;

    // Subtract is ACC + ~BREG + 1, so carry-out set means no borrow
    always_comb begin
        b_term    = s_u_q ? ~breg_q : breg_q;
        carry_sum = {1'b0, acc_q} + {1'b0, b_term} + {{WIDTH{1'b0}}, s_u_q};
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            c_flag_q <= 1'b0;
            z_flag_q <= 1'b0;
        end else if (state_q == EXEC) begin
            c_flag_q <= carry_sum[WIDTH];
            z_flag_q <= (alu_s_i == '0);
        end
    end

    assign c_flag_o = c_flag_q;
    assign z_flag_o = z_flag_q;
`endif

    assign acc_o      = acc_q;
    assign breg_o     = breg_q;
    assign s_u_o      = s_u_q;
    assign done_o     = done_q;
    assign op_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_acc_breg_seq.sv
// Bench for acc_breg_seq: transaction-level model (countdown per command, result applied at retirement)
// compared every cycle, plus directed commands with literal expectations.
module tb_acc_breg_seq;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       op_valid = 1'b0;
    logic [1:0] op = 2'b11;
    logic [7:0] w_in = 8'h00;
    logic [7:0] acc, breg, alu_s;
    logic       s_u, busy, done, ready;
`ifdef ACC_FLAGS_EN
    logic       c_flag, z_flag;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the WIDTH=8 adder-subtractor ALU
    assign alu_s = s_u ? (acc - breg) : (acc + breg);

    acc_breg_seq #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .clr_i      (clr),
        .op_valid_i (op_valid),
        .op_ready_o (ready),
        .op_i       (op),
        .w_in_i     (w_in),
        .acc_o      (acc),
        .breg_o     (breg),
        .s_u_o      (s_u),
        .alu_s_i    (alu_s),
        .busy_o     (busy),
`ifdef ACC_FLAGS_EN
        .c_flag_o   (c_flag),
        .z_flag_o   (z_flag),
`endif
        .done_o     (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: cycles remaining until retirement; results appear when the command retires.
    int         m_cnt = 0;
    int         m_accepts = 0;
    logic [1:0] m_op = 2'b11;
    logic [7:0] m_opnd = 8'h00;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_breg = 8'h00;
    logic       m_su = 1'b0;
    logic       m_done = 1'b0;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;

    always @(posedge clk or posedge clr) begin
        logic [8:0] full;
        if (clr) begin
            m_cnt = 0; m_acc = 8'h00; m_breg = 8'h00; m_su = 1'b0;
            m_done = 1'b0; m_c = 1'b0; m_z = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (op_valid) begin
                    m_op = op; m_opnd = w_in; m_accepts++;
                    m_cnt = (op == 2'b00) ? 2 : (op == 2'b11) ? 1 : 3;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    if (m_op == 2'b00) m_acc = m_opnd;
                    else if (m_op != 2'b11) begin
                        m_breg = m_opnd;
                        m_su   = (m_op == 2'b10);
                        if (m_su) full = {1'b0, m_acc} + {1'b0, ~m_opnd} + 9'd1;
                        else      full = {1'b0, m_acc} + {1'b0, m_opnd};
                        m_acc = full[7:0];
                        m_c   = full[8];
                        m_z   = (full[7:0] == 8'h00);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            chk("ready", ready, m_cnt == 0);
            chk("busy", busy, m_cnt != 0);
            chk("done", done, m_done);
            if (m_cnt == 0) begin
                chk("acc", acc, m_acc);
                chk("breg", breg, m_breg);
                chk("s_u", s_u, m_su);
`ifdef ACC_FLAGS_EN
                chk("c_flag", c_flag, m_c);
                chk("z_flag", z_flag, m_z);
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic cmd(input logic [1:0] o, input logic [7:0] w, input int lat);
        int k, nb, t;
        t = 0;
        while (!ready && t < 20) begin @(negedge clk); t++; end
        if (!ready) chk("ready_timeout", 0, 1);
        op_valid = 1'b1; op = o; w_in = w;
        @(negedge clk);
        op_valid = 1'b0; op = ~o; w_in = ~w;
        k = 0; nb = 0;
        while (!done && k < 10) begin
            if (busy) nb++;
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat);
        chk("busy_cycles", nb, lat);
    endtask

    initial begin
        int ndone, t;
        @(negedge clk);
        chk("rst_acc", acc, 8'h00);
        chk("rst_breg", breg, 8'h00);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        clr = 1'b0;
        @(negedge clk);

        cmd(2'b00, 8'h05, 2);
        chk("lda_acc", acc, 8'h05);
        cmd(2'b01, 8'h03, 3);
        chk("add_breg", breg, 8'h03);
        chk("add_su", s_u, 0);
        chk("add_acc", acc, 8'h08);
        cmd(2'b10, 8'h0A, 3);
        chk("sub_su", s_u, 1);
        chk("sub_acc", acc, 8'hFE);
`ifdef ACC_FLAGS_EN
        chk("sub_c", c_flag, 0);
        chk("sub_z", z_flag, 0);
`endif
        cmd(2'b00, 8'hFF, 2);
        cmd(2'b01, 8'h01, 3);
        chk("wrap_acc", acc, 8'h00);
        cmd(2'b00, 8'h10, 2);
        chk("lda10_acc", acc, 8'h10);
`ifdef ACC_FLAGS_EN
        chk("wrap_c", c_flag, 1);
        chk("wrap_z", z_flag, 1);
`endif

        // NOP held valid for 10 edges: accept, retire, accept, ... -> 5 retirements
        ndone = 0;
        op_valid = 1'b1; op = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            w_in = 8'(i * 29);
            @(negedge clk);
            if (done) ndone++;
        end
        op_valid = 1'b0;
        chk("nop_count", ndone, 5);
        chk("nop_acc", acc, 8'h10);
        chk("nop_breg", breg, 8'h01);

        // Mixed commands with valid held high; the model checks every cycle
        op_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = 2'(i % 4); w_in = 8'(i * 17 + 3);
            @(negedge clk);
        end
        op_valid = 1'b0;
        t = 0;
        while (!ready && t < 10) begin @(negedge clk); t++; end
        chk("mixed_idle", ready, 1);
        @(negedge clk);

        // CLR during EXEC of ADD 0x07
        cmd(2'b00, 8'h20, 2);
        op_valid = 1'b1; op = 2'b01; w_in = 8'h07;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("exec_busy", busy, 1);
        #1 clr = 1'b1;
        #1;
        chk("clr_acc", acc, 8'h00);
        chk("clr_breg", breg, 8'h00);
        chk("clr_su", s_u, 0);
        chk("clr_done", done, 0);
        chk("clr_ready", ready, 1);
        chk("clr_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_no_done", done, 0);
        end
        op_valid = 1'b1; op = 2'b00; w_in = 8'h33;
        @(posedge clk);
        #2 clr = 1'b0;
        @(negedge clk);
        chk("clr_no_accept", busy, 0);
        @(negedge clk);
        chk("post_clr_accept", busy, 1);
        op_valid = 1'b0;
        t = 0;
        while (!done && t < 10) begin @(negedge clk); t++; end
        chk("post_clr_done", done, 1);
        chk("post_clr_acc", acc, 8'h33);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
